// File: rtl/lsu_multibyte.sv
// Byte-serial load/store unit: frames each request as flag, address and data bytes over a UART.
// Optional macro LSU_STORE_ACK_EN makes a store wait for an ack byte (0xA5).
module lsu_multibyte #(
  parameter int DATA_BYTES     = 2,
  parameter int ADDR_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    busy
);
  localparam int DW = 8*DATA_BYTES;
  localparam int AW = 8*ADDR_BYTES;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0] ALAST = 4'(ADDR_BYTES - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_FLAG,
    SEND_ADDR,
    SEND_DATA,
    RECV_DATA,
`ifdef LSU_STORE_ACK_EN
    WAIT_ACK,
`endif
    DONE
  } state_t;

  state_t          state;
  logic            we_q;
  logic [AW-1:0]   addr_sh;
  logic [DW-1:0]   data_sh;
  logic [3:0]      byte_cnt;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   rx_word;
  logic            timed_out;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign timed_out = TO_EN && (tcnt == TLAST);

  // data_sh doubles as outgoing store shifter and incoming load assembler
  always_comb begin
    rx_word      = data_sh << 8;
    rx_word[7:0] = rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      byte_cnt  <= '0;
      tcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          addr_sh  <= req_addr;
          data_sh  <= req_wdata;
          tx_data  <= req_we ? 8'h02 : 8'h01;
          tx_start <= 1'b1;
          state    <= SEND_FLAG;
        end
        SEND_FLAG: if (tx_done) begin
          tx_data  <= addr_sh[AW-1 -: 8];
          addr_sh  <= addr_sh << 8;
          tx_start <= 1'b1;
          byte_cnt <= '0;
          state    <= SEND_ADDR;
        end
        SEND_ADDR: if (tx_done) begin
          if (byte_cnt != ALAST) begin
            byte_cnt <= byte_cnt + 4'd1;
            tx_data  <= addr_sh[AW-1 -: 8];
            addr_sh  <= addr_sh << 8;
            tx_start <= 1'b1;
          end else if (we_q) begin
            byte_cnt <= '0;
            tx_data  <= data_sh[DW-1 -: 8];
            data_sh  <= data_sh << 8;
            tx_start <= 1'b1;
            state    <= SEND_DATA;
          end else begin
            byte_cnt <= '0;
            tcnt     <= '0;
            state    <= RECV_DATA;
          end
        end
        SEND_DATA: if (tx_done) begin
          if (byte_cnt != DLAST) begin
            byte_cnt <= byte_cnt + 4'd1;
            tx_data  <= data_sh[DW-1 -: 8];
            data_sh  <= data_sh << 8;
            tx_start <= 1'b1;
          end else begin
`ifdef LSU_STORE_ACK_EN
            tcnt  <= '0;
            state <= WAIT_ACK;
`else
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= DONE;
`endif
          end
        end
        RECV_DATA: begin
          if (rx_valid) begin
            data_sh  <= rx_word;
            tcnt     <= '0;
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == DLAST) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= rx_word;
              state     <= DONE;
            end
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= DONE;
          end else if (TO_EN) begin
            tcnt <= tcnt + 1'b1;
          end
        end
`ifdef LSU_STORE_ACK_EN
        WAIT_ACK: begin
          if (rx_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= (rx_data != 8'hA5);
            state     <= DONE;
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= DONE;
          end else if (TO_EN) begin
            tcnt <= tcnt + 1'b1;
          end
        end
`endif
        DONE: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_multibyte.sv
// Self-checking bench for lsu_multibyte: directed cases plus randomized traffic
// compared every cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_lsu_multibyte;
  localparam int DB = 4;
  localparam int AB = 2;
  localparam int TO = 16;
  localparam int DW = 8*DB;
  localparam int AW = 8*AB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          tx_start, tx_done, rx_valid, busy;
  logic [7:0]    tx_data, rx_data;

  always #5 clk = ~clk;

  lsu_multibyte #(.DATA_BYTES(DB), .ADDR_BYTES(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy)
  );

  int total = 0;
  int passed = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Transaction model: bytes still owed on the UART, bytes still awaited, idle cycles.
  bit            m_busy = 0, m_start = 0, m_valid = 0, m_err = 0, m_wait = 0, m_store = 0;
  logic [DW-1:0] m_rdata = '0, m_acc = '0;
  logic [7:0]    m_txq[$];
  int            m_need = 0, m_idle = 0;

  task automatic model_step();
    if (reset) begin
      m_busy = 0; m_start = 0; m_valid = 0; m_err = 0; m_wait = 0;
      m_rdata = '0; m_txq.delete(); m_need = 0; m_idle = 0;
    end else begin
      m_start = 0;
      if (m_valid) begin
        m_valid = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_store = req_we; m_txq.delete();
          m_txq.push_back(req_we ? 8'h02 : 8'h01);
          for (int i = AB-1; i >= 0; i--) m_txq.push_back(req_addr[8*i +: 8]);
          if (req_we) for (int i = DB-1; i >= 0; i--) m_txq.push_back(req_wdata[8*i +: 8]);
          m_start = 1;
        end
      end else if (m_txq.size() > 0) begin
        if (tx_done) begin
          void'(m_txq.pop_front());
          if (m_txq.size() > 0) m_start = 1;
          else if (!m_store) begin m_wait = 1; m_need = DB; m_acc = '0; m_idle = 0; end
`ifdef LSU_STORE_ACK_EN
          else begin m_wait = 1; m_need = 1; m_idle = 0; end
`else
          else begin m_valid = 1; m_err = 0; end
`endif
        end
      end else if (m_wait) begin
        if (rx_valid) begin
          m_idle = 0;
          if (m_store) begin
            m_wait = 0; m_valid = 1; m_err = (rx_data != 8'hA5);
          end else begin
            m_acc = (m_acc << 8) | DW'(rx_data);
            m_need--;
            if (m_need == 0) begin m_wait = 0; m_valid = 1; m_err = 0; m_rdata = m_acc; end
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_wait = 0; m_valid = 1; m_err = 1; m_rdata = '0; end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Per-cycle compare plus response/tx logging for the directed cases.
  bit            chk_en = 0;
  int            rsp_count = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic [7:0]    tx_log[$];

  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin rsp_count++; last_rdata = rsp_rdata; last_err = rsp_err; end
    if (tx_start) tx_log.push_back(tx_data);
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(!m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("tx_start", 64'(tx_start), 64'(m_start));
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      check("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      if (m_valid) check("rsp_err", 64'(rsp_err), 64'(m_err));
      if (m_busy && m_txq.size() > 0) check("tx_data", 64'(tx_data), 64'(m_txq[0]));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("issue_accepted", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic serve_tx(input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      int n = 0;
      while (!tx_start && n < 50) begin tick(); n++; end
      check("tx_start_seen", 64'(tx_start), 64'(1));
      tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int c0);
    int n = 0;
    while (rsp_count == c0 && n < 100) begin tick(); n++; end
    check("rsp_seen_once", 64'(rsp_count - c0), 64'(1));
    tick();
    check("rsp_one_cycle", 64'(rsp_valid), 64'(0));
    check("ready_after_rsp", 64'(req_ready), 64'(1));
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, 64'(tx_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < tx_log.size()) check(name, 64'(tx_log[i]), 64'(exp[i]));
  endtask

  initial begin
    int c0, n, pend, rx_div;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    tx_done = 0; rx_valid = 0; rx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    chk_en = 1;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'(1));

    // Load 0x1234 -> 0xDEADBEEF
    tx_log.delete(); c0 = rsp_count;
    issue(1'b0, 16'h1234, '0);
    serve_tx(3);
    rx_send(8'hDE, 1); rx_send(8'hAD, 0); rx_send(8'hBE, 3); rx_send(8'hEF, 2);
    wait_rsp(c0);
    check("ld_rdata", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    check("ld_err", 64'(last_err), 64'(0));
    check_log("ld_tx", '{8'h01, 8'h12, 8'h34});

    // Store 0x0080 <- 0xCAFEBEEF; read data must stay untouched
    tx_log.delete(); c0 = rsp_count;
    issue(1'b1, 16'h0080, 32'hCAFE_BEEF);
    serve_tx(7);
`ifdef LSU_STORE_ACK_EN
    rx_send(8'h5A, 1);
    wait_rsp(c0);
    check("st_bad_ack_err", 64'(last_err), 64'(1));
    tx_log.delete(); c0 = rsp_count;
    issue(1'b1, 16'h0080, 32'hCAFE_BEEF);
    serve_tx(7);
    rx_send(8'hA5, 2);
    wait_rsp(c0);
    check("st_good_ack_err", 64'(last_err), 64'(0));
`else
    check("st_rsp_next_cycle", 64'(rsp_valid), 64'(1));
    check("st_err", 64'(rsp_err), 64'(0));
    tick();
`endif
    check("st_rdata_kept", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);
    check_log("st_tx", '{8'h02, 8'h00, 8'h80, 8'hCA, 8'hFE, 8'hBE, 8'hEF});

    // Reset in the middle of a load's receive phase
    c0 = rsp_count;
    issue(1'b0, 16'h4242, '0);
    serve_tx(3);
    rx_send(8'h11, 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_tx_start", 64'(tx_start), 64'(0));
    check("mid_rst_tx_data", 64'(tx_data), 64'(0));
    check("mid_rst_rdata", 64'(rsp_rdata), 64'(0));
    check("mid_rst_err", 64'(rsp_err), 64'(0));
    tick(); tick();
    reset = 1'b0;
    rx_send(8'h22, 1); rx_send(8'h33, 1);
    repeat (20) tick();
    check("mid_rst_no_rsp", 64'(rsp_count - c0), 64'(0));
    c0 = rsp_count;
    issue(1'b0, 16'hA55A, '0);
    serve_tx(3);
    rx_send(8'h01, 0); rx_send(8'h02, 0); rx_send(8'h03, 0); rx_send(8'h04, 0);
    wait_rsp(c0);
    check("post_rst_ld_rdata", 64'(last_rdata), 64'h0000_0000_0102_0304);

    // Load timeout: one byte then silence for exactly TO cycles
    issue(1'b0, 16'h00AA, '0);
    serve_tx(3);
    rx_send(8'h77, 0);
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("to_idle_cycles", 64'(n), 64'(16));
    check("to_err", 64'(rsp_err), 64'(1));
    check("to_rdata", 64'(rsp_rdata), 64'(0));
    tick();

    // Randomized traffic with varying rx rates, spurious strobes and reset pulses
    c0 = rsp_count; pend = 0; rx_div = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) rx_div = ((cyc/250) % 3 == 0) ? 2 : (((cyc/250) % 3 == 1) ? 5 : 40);
      if (cyc % 1000 == 777) begin
        reset = 1'b1; tick(); tick(); reset = 1'b0; pend = 0;
      end
      req_valid = ($urandom_range(0, 3) == 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      tx_done   = 1'b0;
      if (tx_start) pend = $urandom_range(1, 4);
      if (pend > 0) begin pend--; tx_done = (pend == 0); end
      else tx_done = ($urandom_range(0, 15) == 0);
      rx_valid = ($urandom_range(0, rx_div-1) == 0);
      rx_data  = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
      tick();
    end
    req_valid = 0; tx_done = 0; rx_valid = 0;
    check("random_rsp_seen", 64'(rsp_count > c0), 64'(1));
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
